// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared constants, state type and score compare for the LeNet argmax head
package lenet_pkg;

  localparam int DW          = 16;
  localparam int COLS        = 4;
  localparam int NUM_CLASSES = 10;
  localparam int ADDR_W      = 8;
  localparam int CLASS_W     = 4;
  localparam int FINAL_LAYER = 5;
  localparam int NUM_WORDS   = (NUM_CLASSES + COLS - 1) / COLS;

  localparam logic [DW-1:0] SCORE_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  // Candidate a displaces b on a strictly greater score, or an equal score at a lower class.
  function automatic logic beats(input logic [DW-1:0]      a_val,
                                 input logic [CLASS_W-1:0] a_cls,
                                 input logic [DW-1:0]      b_val,
                                 input logic [CLASS_W-1:0] b_cls);
    return ($signed(a_val) > $signed(b_val)) || ((a_val == b_val) && (a_cls < b_cls));
  endfunction

endpackage

// File: rtl/argmax_lane_reduce.sv
// rtl/argmax_lane_reduce.sv - combinational signed argmax across the lanes of one write word
module argmax_lane_reduce
  import lenet_pkg::*;
(
  input  logic [DW*COLS-1:0]      lane_data,
  input  logic [CLASS_W*COLS-1:0] lane_cls,
  input  logic [COLS-1:0]         lane_mask,
  output logic [DW-1:0]           best_val,
  output logic [CLASS_W-1:0]      best_cls
);

  always_comb begin
    logic              hit;
    logic [DW-1:0]     v;
    logic [CLASS_W-1:0] c;
    hit      = 1'b0;
    v        = '0;
    c        = '0;
    best_val = SCORE_MIN;
    best_cls = '0;
    for (int k = 0; k < COLS; k++) begin
      v = lane_data[DW*k +: DW];
      c = lane_cls[CLASS_W*k +: CLASS_W];
      // The first unmasked lane seeds the search so a lone SCORE_MIN lane still reports its class.
      if (lane_mask[k] && (!hit || beats(v, c, best_val, best_cls))) begin
        hit      = 1'b1;
        best_val = v;
        best_cls = c;
      end
    end
  end

endmodule

// File: rtl/lenet_argmax_head.sv
// rtl/lenet_argmax_head.sv - pipelined argmax over the final FC layer write stream
module lenet_argmax_head
  import lenet_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [3:0]           layer_index,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr_w,
  input  logic [DW*COLS-1:0]   data_in,
  output logic [CLASS_W-1:0]   predict_index,
  output logic [DW-1:0]        max_score,
  output logic                 predict_valid,
  output logic                 busy,
  output logic                 dup_err,
  output logic                 range_err
);

  localparam int CW2   = ADDR_W + 2;
  localparam int CNT_W = $clog2(NUM_WORDS + 1);

  state_e                  state_q, state_d;
  logic                    layer_final, layer_final_q, do_clear;
  logic                    accept, in_range, dup, write_ok;
  logic [NUM_WORDS-1:0]    word_onehot, bitmap_q;
  logic [COLS-1:0]         lane_mask;
  logic [CLASS_W*COLS-1:0] lane_cls;
  logic [DW-1:0]           word_val;
  logic [CLASS_W-1:0]      word_cls;
  logic                    s1_valid_q;
  logic [DW-1:0]           s1_val_q, best_val_q;
  logic [CLASS_W-1:0]      s1_cls_q, best_cls_q;
  logic [CNT_W-1:0]        count_q;
  logic                    dup_err_q, range_err_q;

  assign layer_final = (layer_index == 4'(FINAL_LAYER));
  // Entering the final layer restarts accumulation so consecutive images need no host clear.
  assign do_clear    = clear | (layer_final & ~layer_final_q);
  assign accept      = wr_en & layer_final & (state_q != DONE);
  assign in_range    = (addr_w < ADDR_W'(NUM_WORDS));
  assign dup         = |(bitmap_q & word_onehot);
  assign write_ok    = accept & in_range & ~dup;

  always_comb begin
    word_onehot = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      if (addr_w == ADDR_W'(w)) word_onehot[w] = 1'b1;
  end

  // Class numbers are formed wide so out-of-range addresses cannot alias into valid classes.
  always_comb begin
    logic [CW2-1:0] cls_wide;
    cls_wide  = '0;
    lane_mask = '0;
    lane_cls  = '0;
    for (int k = 0; k < COLS; k++) begin
      cls_wide = CW2'(addr_w) * CW2'(COLS) + CW2'(k);
      lane_mask[k] = (cls_wide < CW2'(NUM_CLASSES));
      lane_cls[CLASS_W*k +: CLASS_W] = CLASS_W'(cls_wide);
    end
  end

  argmax_lane_reduce u_reduce (
    .lane_data (data_in),
    .lane_cls  (lane_cls),
    .lane_mask (lane_mask),
    .best_val  (word_val),
    .best_cls  (word_cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (do_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (write_ok) state_d = ACCUM;
        ACCUM:   if (s1_valid_q && (count_q == CNT_W'(NUM_WORDS - 1))) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_final_q <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_val_q      <= '0;
      s1_cls_q      <= '0;
      bitmap_q      <= '0;
      best_val_q    <= SCORE_MIN;
      best_cls_q    <= '0;
      count_q       <= '0;
      dup_err_q     <= 1'b0;
      range_err_q   <= 1'b0;
    end else begin
      layer_final_q <= layer_final;
      if (do_clear) begin
        s1_valid_q  <= 1'b0;
        s1_val_q    <= '0;
        s1_cls_q    <= '0;
        bitmap_q    <= '0;
        best_val_q  <= SCORE_MIN;
        best_cls_q  <= '0;
        count_q     <= '0;
        dup_err_q   <= 1'b0;
        range_err_q <= 1'b0;
      end else begin
        s1_valid_q <= write_ok;
        if (write_ok) begin
          s1_val_q <= word_val;
          s1_cls_q <= word_cls;
          bitmap_q <= bitmap_q | word_onehot;
        end
        if (accept && !in_range)       range_err_q <= 1'b1;
        if (accept && in_range && dup) dup_err_q   <= 1'b1;
        if (s1_valid_q) begin
          count_q <= count_q + CNT_W'(1);
          if (beats(s1_val_q, s1_cls_q, best_val_q, best_cls_q)) begin
            best_val_q <= s1_val_q;
            best_cls_q <= s1_cls_q;
          end
        end
      end
    end
  end

  assign predict_valid = (state_q == DONE);
  assign predict_index = predict_valid ? best_cls_q : '0;
  assign max_score     = predict_valid ? best_val_q : '0;
  assign busy          = (state_q == ACCUM) | s1_valid_q;
  assign dup_err       = dup_err_q;
  assign range_err     = range_err_q;

endmodule

// File: tb/tb_lenet_argmax_head.sv
// tb/tb_lenet_argmax_head.sv - directed and randomized bench for lenet_argmax_head
module tb_lenet_argmax_head;

  logic        clk = 1'b0;
  logic        rst_n, clear, wr_en;
  logic [3:0]  layer_index;
  logic [7:0]  addr_w;
  logic [63:0] data_in;
  logic [3:0]  predict_index;
  logic [15:0] max_score;
  logic        predict_valid, busy, dup_err, range_err;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sc [12];

  always #5 clk = ~clk;

  lenet_argmax_head dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .layer_index   (layer_index),
    .wr_en         (wr_en),
    .addr_w        (addr_w),
    .data_in       (data_in),
    .predict_index (predict_index),
    .max_score     (max_score),
    .predict_valid (predict_valid),
    .busy          (busy),
    .dup_err       (dup_err),
    .range_err     (range_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan classes 0..9 in order, keep the first strictly largest signed score.
  task automatic ref_argmax(output int idx, output logic [15:0] best);
    idx = 0;
    for (int c = 1; c < 10; c++)
      if ($signed(sc[c]) > $signed(sc[idx])) idx = c;
    best = sc[idx];
  endtask

  function automatic logic [63:0] word_of(input int a);
    return {sc[a*4+3], sc[a*4+2], sc[a*4+1], sc[a*4]};
  endfunction

  task automatic drive(input logic we, input int a, input logic [63:0] d);
    @(negedge clk);
    wr_en   = we;
    addr_w  = 8'(a);
    data_in = d;
  endtask

  task automatic finish_check(input string tag);
    int          ei;
    logic [15:0] es;
    drive(1'b0, 0, 64'h0);
    check({tag, "_pv_early"}, {31'h0, predict_valid}, 32'h0);
    check({tag, "_busy_mid"}, {31'h0, busy}, 32'h1);
    @(negedge clk);
    ref_argmax(ei, es);
    check({tag, "_pv"},    {31'h0, predict_valid}, 32'h1);
    check({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check({tag, "_idx"},   {28'h0, predict_index}, 32'(ei));
    check({tag, "_score"}, {16'h0, max_score}, {16'h0, es});
  endtask

  task automatic run_image(input int a0, input int a1, input int a2, input string tag);
    drive(1'b1, a0, word_of(a0));
    drive(1'b1, a1, word_of(a1));
    drive(1'b1, a2, word_of(a2));
    finish_check(tag);
  endtask

  task automatic pulse_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check({tag, "_clr_pv"}, {31'h0, predict_valid}, 32'h0);
  endtask

  initial begin
    int          r, o0, o1, o2;
    logic [3:0]  held_idx;
    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; layer_index = 4'd5;
    addr_w = '0; data_in = '0;
    #3;
    check("rst_pv",    {31'h0, predict_valid}, 32'h0);
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_idx",   {28'h0, predict_index}, 32'h0);
    check("rst_score", {16'h0, max_score}, 32'h0);
    check("rst_errs",  {30'h0, dup_err, range_err}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic image, classes 10 and 11 must be ignored
    sc = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'h0300,
           16'd5, 16'd6, 16'h7FFF, 16'h7FFF};
    run_image(0, 1, 2, "t1");
    check("t1_idx_const",   {28'h0, predict_index}, 32'd7);
    check("t1_score_const", {16'h0, max_score}, 32'h0300);

    // 2: tie resolved to the lower class regardless of arrival order
    for (int c = 0; c < 12; c++) sc[c] = 16'h0010;
    sc[2] = 16'h0100; sc[5] = 16'h0100;
    pulse_clear("t2a");
    run_image(0, 1, 2, "t2a");
    check("t2a_idx_const", {28'h0, predict_index}, 32'd2);
    pulse_clear("t2b");
    run_image(1, 0, 2, "t2b");
    check("t2b_idx_const", {28'h0, predict_index}, 32'd2);

    // 3: all negative
    for (int c = 0; c < 12; c++) sc[c] = 16'(-(c + 1));
    pulse_clear("t3");
    run_image(2, 1, 0, "t3");
    check("t3_score_const", {16'h0, max_score}, 32'hFFFF);

    // 4: duplicate and out-of-range writes are dropped but flagged
    for (int c = 0; c < 12; c++) sc[c] = 16'(c * 3);
    pulse_clear("t4");
    drive(1'b1, 0, word_of(0));
    drive(1'b1, 0, {4{16'h7FFF}});
    drive(1'b1, 3, {4{16'h7FFF}});
    drive(1'b1, 1, word_of(1));
    drive(1'b1, 2, word_of(2));
    finish_check("t4");
    check("t4_dup", {31'h0, dup_err}, 32'h1);
    check("t4_rng", {31'h0, range_err}, 32'h1);

    // 5: wrong layer accepts nothing; async reset discards a partial image
    pulse_clear("t5");
    layer_index = 4'd4;
    drive(1'b1, 0, word_of(0));
    drive(1'b1, 1, word_of(1));
    check("t5_l4_busy", {31'h0, busy}, 32'h0);
    drive(1'b1, 2, word_of(2));
    drive(1'b0, 0, 64'h0);
    repeat (2) @(negedge clk);
    check("t5_l4_pv", {31'h0, predict_valid}, 32'h0);
    layer_index = 4'd5;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 12; c++) sc[c] = 16'($urandom());
    drive(1'b1, 1, word_of(1));
    drive(1'b1, 0, word_of(0));
    drive(1'b0, 0, 64'h0);
    check("t5_part_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_pv",   {31'h0, predict_valid}, 32'h0);
    check("t5_rst_out",  {12'h0, predict_index, max_score}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_after_pv", {31'h0, predict_valid}, 32'h0);
    run_image(0, 2, 1, "t5");

    // writes while DONE set no flags and leave the result alone
    held_idx = predict_index;
    drive(1'b1, 3, 64'h0);
    drive(1'b1, 0, {4{16'h7FFF}});
    drive(1'b0, 0, 64'h0);
    @(negedge clk);
    check("done_flags", {30'h0, dup_err, range_err}, 32'h0);
    check("done_idx",   {28'h0, predict_index}, {28'h0, held_idx});

    // 6: clear coincident with a write drops the write
    @(negedge clk);
    clear = 1'b1; wr_en = 1'b1; addr_w = 8'd0; data_in = {4{16'h7FFF}};
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    check("t6_pv",   {31'h0, predict_valid}, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    for (int c = 0; c < 12; c++) sc[c] = 16'h0020;
    sc[9] = 16'h0400;
    run_image(2, 0, 1, "t6");
    check("t6_idx_const", {28'h0, predict_index}, 32'd9);

    // randomized images, alternating host clear and layer re-entry
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < 12; c++)
        sc[c] = (n % 3 == 0) ? 16'($urandom_range(0, 3) * 256) : 16'($urandom());
      if (n % 2 == 0) begin
        pulse_clear("rnd");
      end else begin
        @(negedge clk); layer_index = 4'd4;
        @(negedge clk); layer_index = 4'd5;
        repeat (2) @(negedge clk);
        check("rnd_reentry_pv", {31'h0, predict_valid}, 32'h0);
      end
      r = $urandom_range(0, 5);
      case (r)
        0: begin o0 = 0; o1 = 1; o2 = 2; end
        1: begin o0 = 0; o1 = 2; o2 = 1; end
        2: begin o0 = 1; o1 = 0; o2 = 2; end
        3: begin o0 = 1; o1 = 2; o2 = 0; end
        4: begin o0 = 2; o1 = 0; o2 = 1; end
        default: begin o0 = 2; o1 = 1; o2 = 0; end
      endcase
      run_image(o0, o1, o2, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
